multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control unit for the RV32I-subset datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the ALU's 4-bit `alu_op` and operand-select lines, consumes the ALU's `zero` flag to resolve BEQ, and issues register-file, memory and PC strobes. It sits directly upstream of the ALU and owns the instruction register (IR).

## Interface
No parameters.
- `clk`  in  1  single system clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  instruction memory has valid `instr` this cycle
- `instr`  in  32  fetched instruction word
- `mem_ready`  in  1  data memory completed the requested access this cycle
- `zero`  in  1  ALU zero flag; sampled in EX
- `ir_write`  out  1  IR load strobe
- `alu_src`  out  1  0 selects rs2 as ALU op2; 1 selects immediate
- `alu_op`  out  4  ALU operation code
- `mem_read`  out  1  data-memory read request
- `mem_write`  out  1  data-memory write request
- `reg_write`  out  1  register-file write enable
- `mem_to_reg`  out  1  writeback source: 1 selects memory data, 0 selects ALU result
- `pc_write`  out  1  PC update strobe
- `pc_src`  out  1  0 selects PC+4; 1 selects branch target
- `illegal`  out  1  unsupported instruction, 1-cycle pulse in WB
- `state`  out  3  current FSM state, for debug

## Operation
- **States:** IF=0, ID=1, EX=2, MEM=3, WB=4. Encodings 5–7 are unreachable; if entered, the FSM goes to IF on the next cycle.
- **IF:**
  - `ir_write`=`instr_valid`.
  - On `instr_valid`=1: IR<=`instr`, go to ID. Otherwise stay in IF.
- **ID:** one cycle, then EX. No strobes.
- **EX:** one cycle, then MEM.
  - `alu_op` and `alu_src` are decoded from IR.
  - `branch_taken` register <= `is_beq & zero`.
- **MEM:**
  - Load: `mem_read`=1.
  - Store: `mem_write`=1.
  - For load/store, hold the request and stay in MEM until `mem_ready`=1 is sampled, then go to WB.
  - All other instructions: one cycle in MEM, no requests, `mem_ready` ignored.
- **WB:** one cycle, then IF.
  - `pc_write`=1, `pc_src`=`branch_taken`.
  - `reg_write`=1 for R-type, I-ALU and load. `mem_to_reg`=1 for load only.
  - `illegal`=1 if the opcode is unsupported. Unsupported instructions assert no `reg_write` or memory strobe.
- **Opcodes decoded:**
  - 0110011 R-type
  - 0010011 I-ALU
  - 0000011 load
  - 0100011 store
  - 1100011 with funct3=000 (BEQ)
  - All other opcodes, including BEQ's opcode with funct3≠000, are unsupported.
- **ALU codes:** AND 0000, OR 0001, ADD 0010, SUB 0110, LESS 0100, SLL 1000, SRL 1001, SRA 1010, XOR 0101.
- **R-type decode, funct3:**
  - 000: ADD if funct7=0000000, SUB if funct7=0100000
  - 001: SLL
  - 010: LESS
  - 100: XOR
  - 101: SRL if funct7=0000000, SRA if funct7=0100000
  - 110: OR
  - 111: AND
  - Any other funct7 on 000/101 is unsupported.
- **I-ALU decode:** same funct3 table, but funct3=000 is always ADD (funct7 ignored). funct3=101 uses funct7 exactly as for R-type.
- **Fixed ALU ops by class:** load/store use ADD, `alu_src`=1. BEQ uses SUB, `alu_src`=0. I-ALU uses `alu_src`=1. R-type uses `alu_src`=0.
- **Outside EX:** `alu_op`=0010 and `alu_src`=0.

## Timing
- **Reset:** while `rst`=1, state<=IF, IR<=0, `branch_taken`<=0. All outputs are 0, except `alu_op`=0010 and `state`=0. The first IF cycle with live strobes is the first cycle with `rst`=0.
- **Output timing:** outputs are combinational from the state register, IR and `branch_taken`. There is no output register.
- **Latency:**
  - Minimum 5 cycles per instruction: IF, ID, EX, MEM, WB.
  - Each IF cycle with `instr_valid`=0 adds 1 cycle.
  - Each MEM cycle with `mem_ready`=0 on load/store adds 1 cycle.
- **Handshake:**
  - `mem_read`/`mem_write` stay high and stable until and including the cycle `mem_ready`=1.
  - `ir_write` is high only in IF cycles with `instr_valid`=1.
- **`zero` sampling:** `zero` is sampled only at the end of EX. Values of `zero` in other states have no effect.
- **Reset mid-operation:** `rst` in any state, including a stalled MEM, drops all strobes the same cycle and restarts at IF. No partial writeback occurs.

## Test plan
- **Reset:** hold `rst` 3 cycles, `instr_valid`=0 -> all strobes 0, `alu_op`=0010, `state`=0. After release, `state` stays 0 until `instr_valid`.
- **SUB R-type:** 0x40208033 (sub x0,x1,x2) -> `ir_write` in IF. EX shows `alu_op`=0110, `alu_src`=0. WB shows `reg_write`=1, `mem_to_reg`=0, `pc_write`=1, `pc_src`=0. 5 cycles total.
- **SRAI and XORI:** SRAI 0x4030D093 -> EX `alu_op`=1010, `alu_src`=1. XORI 0x0FF14093 -> EX `alu_op`=0101.
- **Load with stall:** LW 0x0000A083, `mem_ready` low 2 cycles -> `mem_read` high 3 cycles. WB shows `reg_write`=1, `mem_to_reg`=1. 7 cycles total.
- **BEQ resolution:** BEQ 0x00208463 with `zero`=1 in EX -> WB `pc_src`=1, no `reg_write`. Same instruction with `zero`=0 -> `pc_src`=0. A `zero` toggle outside EX has no effect.
- **Illegal opcode and reset mid-store:**
  - Opcode 1111111 -> `illegal` pulses 1 cycle in WB, no `reg_write`/`mem_*`, `pc_write`=1.
  - SW with `mem_ready`=0 and `rst` asserted in MEM -> `mem_write` drops the same cycle, `state`=0 after.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control-unit bus: instruction fetch, memory handshake, ALU flag and
// the datapath strobes driven by the multicycle controller.
interface multicycle_ctrl_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        ir_write;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        pc_write;
    logic        pc_src;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  instr_valid, instr, mem_ready, zero,
        output ir_write, alu_src, alu_op, mem_read, mem_write,
        output reg_write, mem_to_reg, pc_write, pc_src, illegal, state
    );

    modport slave (
        output instr_valid, instr, mem_ready, zero,
        input  ir_write, alu_src, alu_op, mem_read, mem_write,
        input  reg_write, mem_to_reg, pc_write, pc_src, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset controller: IF/ID/EX/MEM/WB sequencing,
// IR ownership, ALU op decode and BEQ resolution.
module multicycle_ctrl (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_LESS = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b0101;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] ir;
    logic        branch_taken;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_r;
    logic       is_i;
    logic       is_ld;
    logic       is_st;
    logic       is_beq;
    logic [3:0] fn_op;
    logic       fn_ok;
    logic [3:0] dec_op;
    logic       dec_src;
    logic       supported;
    logic       unused_ir;

    assign opc = ir[6:0];
    assign f3  = ir[14:12];
    assign f7  = ir[31:25];
    assign unused_ir = ^{ir[24:15], ir[11:7]};

    assign is_r   = (opc == 7'b0110011);
    assign is_i   = (opc == 7'b0010011);
    assign is_ld  = (opc == 7'b0000011);
    assign is_st  = (opc == 7'b0100011);
    assign is_beq = (opc == 7'b1100011) && (f3 == 3'b000);

    // Shared funct3 table; only R-type add/sub looks at funct7 on 000
    always_comb begin
        fn_op = OP_ADD;
        fn_ok = 1'b1;
        case (f3)
            3'b000: begin
                if (is_i || f7 == 7'b0000000) begin
                    fn_op = OP_ADD;
                end else if (f7 == 7'b0100000) begin
                    fn_op = OP_SUB;
                end else begin
                    fn_ok = 1'b0;
                end
            end
            3'b001: fn_op = OP_SLL;
            3'b010: fn_op = OP_LESS;
            3'b100: fn_op = OP_XOR;
            3'b101: begin
                if (f7 == 7'b0000000) begin
                    fn_op = OP_SRL;
                end else if (f7 == 7'b0100000) begin
                    fn_op = OP_SRA;
                end else begin
                    fn_ok = 1'b0;
                end
            end
            3'b110: fn_op = OP_OR;
            3'b111: fn_op = OP_AND;
            default: fn_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec_op    = OP_ADD;
        dec_src   = 1'b0;
        supported = 1'b0;
        unique case (1'b1)
            is_r: begin
                dec_op    = fn_op;
                supported = fn_ok;
            end
            is_i: begin
                dec_op    = fn_op;
                dec_src   = 1'b1;
                supported = fn_ok;
            end
            is_ld, is_st: begin
                dec_src   = 1'b1;
                supported = 1'b1;
            end
            is_beq: begin
                dec_op    = OP_SUB;
                supported = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IF;
            ir           <= 32'd0;
            branch_taken <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IF && bus.instr_valid) begin
                ir <= bus.instr;
            end
            if (state_q == S_EX) begin
                branch_taken <= is_beq & bus.zero;
            end
        end
    end

    // Reset gates every strobe in the same cycle, even mid-access
    always_comb begin
        state_d        = S_IF;
        bus.ir_write   = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_op     = OP_ADD;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.illegal    = 1'b0;
        case (state_q)
            S_IF: begin
                bus.ir_write = bus.instr_valid & ~rst;
                state_d      = bus.instr_valid ? S_ID : S_IF;
            end
            S_ID: state_d = S_EX;
            S_EX: begin
                if (!rst) begin
                    bus.alu_op  = dec_op;
                    bus.alu_src = dec_src;
                end
                state_d = S_MEM;
            end
            S_MEM: begin
                if (is_ld || is_st) begin
                    bus.mem_read  = is_ld & ~rst;
                    bus.mem_write = is_st & ~rst;
                    state_d       = bus.mem_ready ? S_WB : S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (!rst) begin
                    bus.pc_write   = 1'b1;
                    bus.pc_src     = branch_taken;
                    bus.reg_write  = supported & (is_r | is_i | is_ld);
                    bus.mem_to_reg = is_ld;
                    bus.illegal    = ~supported;
                end
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver queues the expected
// per-cycle output vector, a negedge monitor pops and compares.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] SRA = 4'b1010;
    localparam logic [3:0] XOR = 4'b0101;

    typedef struct {
        logic [15:0] v;
        string       n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] act;
    assign act = {bus.ir_write, bus.alu_src, bus.alu_op, bus.mem_read,
                  bus.mem_write, bus.reg_write, bus.mem_to_reg,
                  bus.pc_write, bus.pc_src, bus.illegal, bus.state};

    // Field order: st, op, src, ir_write, mem_read, mem_write,
    // reg_write, mem_to_reg, pc_write, pc_src, illegal
    function automatic logic [15:0] ev(
        input logic [2:0] st, input logic [3:0] op, input logic src,
        input logic iw, input logic mr, input logic mw, input logic rw,
        input logic m2r, input logic pw, input logic ps, input logic ill);
        return {iw, src, op, mr, mw, rw, m2r, pw, ps, ill, st};
    endfunction

    task automatic step(input logic r, input logic iv,
                        input logic [31:0] ins, input logic mrdy,
                        input logic z, input logic [15:0] e,
                        input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst             = r;
        bus.instr_valid = iv;
        bus.instr       = ins;
        bus.mem_ready   = mrdy;
        bus.zero        = z;
        x.v = e;
        x.n = nm;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            checks++;
            if (act !== x.v) begin
                errors++;
                $display("FAIL %s got %b want %b", x.n, act, x.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] I_SUB  = 32'h40208033;
    localparam logic [31:0] I_SRAI = 32'h4030D093;
    localparam logic [31:0] I_XORI = 32'h0FF14093;
    localparam logic [31:0] I_LW   = 32'h0000A083;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_SW   = 32'h0020A023;

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.mem_ready   = 1'b0;
        bus.zero        = 1'b0;

        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, ev(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset");
        for (int i = 0; i < 2; i++)
            step(0, 0, 0, 0, 0, ev(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "idle");

        step(0, 1, I_SUB, 0, 0, ev(0, ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0), "sub_if");
        step(0, 0, 0, 0, 0, ev(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sub_id");
        step(0, 0, 0, 0, 0, ev(2, SUB, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sub_ex");
        step(0, 0, 0, 0, 0, ev(3, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sub_mem");
        step(0, 0, 0, 0, 0, ev(4, ADD, 0, 0, 0, 0, 1, 0, 1, 0, 0), "sub_wb");

        step(0, 1, I_SRAI, 0, 0, ev(0, ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0), "srai_if");
        step(0, 0, 0, 0, 0, ev(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "srai_id");
        step(0, 0, 0, 0, 0, ev(2, SRA, 1, 0, 0, 0, 0, 0, 0, 0, 0), "srai_ex");
        step(0, 0, 0, 0, 0, ev(3, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "srai_mem");
        step(0, 0, 0, 0, 0, ev(4, ADD, 0, 0, 0, 0, 1, 0, 1, 0, 0), "srai_wb");

        step(0, 0, 0, 0, 0, ev(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "xori_wait");
        step(0, 1, I_XORI, 0, 0, ev(0, ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0), "xori_if");
        step(0, 0, 0, 0, 0, ev(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "xori_id");
        step(0, 0, 0, 0, 0, ev(2, XOR, 1, 0, 0, 0, 0, 0, 0, 0, 0), "xori_ex");
        step(0, 0, 0, 0, 0, ev(3, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "xori_mem");
        step(0, 0, 0, 0, 0, ev(4, ADD, 0, 0, 0, 0, 1, 0, 1, 0, 0), "xori_wb");

        step(0, 1, I_LW, 0, 0, ev(0, ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0), "lw_if");
        step(0, 0, 0, 0, 0, ev(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_id");
        step(0, 0, 0, 0, 0, ev(2, ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0), "lw_ex");
        step(0, 0, 0, 0, 0, ev(3, ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0), "lw_stall1");
        step(0, 0, 0, 0, 0, ev(3, ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0), "lw_stall2");
        step(0, 0, 0, 1, 0, ev(3, ADD, 0, 0, 1, 0, 0, 0, 0, 0, 0), "lw_ready");
        step(0, 0, 0, 0, 0, ev(4, ADD, 0, 0, 0, 0, 1, 1, 1, 0, 0), "lw_wb");

        step(0, 1, I_BEQ, 1, 0, ev(0, ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0), "beqt_if");
        step(0, 0, 0, 0, 0, ev(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "beqt_id");
        step(0, 0, 0, 0, 1, ev(2, SUB, 0, 0, 0, 0, 0, 0, 0, 0, 0), "beqt_ex");
        step(0, 0, 0, 1, 0, ev(3, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "beqt_mem");
        step(0, 0, 0, 0, 0, ev(4, ADD, 0, 0, 0, 0, 0, 0, 1, 1, 0), "beqt_wb");

        step(0, 1, I_BEQ, 0, 1, ev(0, ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0), "beqn_if");
        step(0, 0, 0, 0, 1, ev(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "beqn_id");
        step(0, 0, 0, 0, 0, ev(2, SUB, 0, 0, 0, 0, 0, 0, 0, 0, 0), "beqn_ex");
        step(0, 0, 0, 0, 1, ev(3, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "beqn_mem");
        step(0, 0, 0, 0, 1, ev(4, ADD, 0, 0, 0, 0, 0, 0, 1, 0, 0), "beqn_wb");

        step(0, 1, I_BAD, 0, 0, ev(0, ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0), "ill_if");
        step(0, 0, 0, 0, 0, ev(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_id");
        step(0, 0, 0, 0, 0, ev(2, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_ex");
        step(0, 0, 0, 1, 0, ev(3, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_mem");
        step(0, 0, 0, 0, 0, ev(4, ADD, 0, 0, 0, 0, 0, 0, 1, 0, 1), "ill_wb");
        step(0, 0, 0, 0, 0, ev(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_after");

        step(0, 1, I_SW, 0, 0, ev(0, ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0), "sw_if");
        step(0, 0, 0, 0, 0, ev(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw_id");
        step(0, 0, 0, 0, 0, ev(2, ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sw_ex");
        step(0, 0, 0, 0, 0, ev(3, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0), "sw_stall1");
        step(0, 0, 0, 0, 0, ev(3, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0), "sw_stall2");
        step(1, 0, 0, 0, 0, ev(3, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw_rst");
        step(0, 0, 0, 0, 0, ev(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw_after");
        step(0, 0, 0, 1, 0, ev(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw_idle");

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
